// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: two-requester round-robin arbiter driving a shared 1-bit mux.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   rst_n      - synchronous active-low reset
//   req_a      - requester A wants the shared output
//   req_b      - requester B wants the shared output
//   A          - requester A data bit
//   B          - requester B data bit
//   grant_a    - registered, A owns the output
//   grant_b    - registered, B owns the output
//   Select_bit - mux select, 0 = A, 1 = B
//   Out        - shared muxed data bit (0 while idle)
//   preempt    - one-cycle pulse coincident with a forced timeout hand-over
//
// Parameter TIMEOUT_CYCLES (2..255) sets the maximum consecutive grant cycles
// before the holder is forced to hand over to a waiting requester. The forced
// hand-over only exists when the macro MUX_ARB_TIMEOUT_EN is defined; otherwise
// preempt is tied low and TIMEOUT_CYCLES has no effect.

module mux_rr_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic A,
  input  logic B,
  output logic grant_a,
  output logic grant_b,
  output logic Select_bit,
  output logic Out,
  output logic preempt
);

  typedef enum logic [1:0] {
    StIdle,
    StGntA,
    StGntB
  } state_e;

  state_e state_q, state_d;
  // 0 = A was granted last, 1 = B was granted last
  logic   last_grant_q, last_grant_d;
  logic   grant_a_q, grant_b_q;
  logic   preempt_q, preempt_d;
  logic   timeout_hit;
  logic   grant_entry;

  assign grant_entry = (state_d != state_q) && (state_d != StIdle);

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLimit = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] hold_cnt_q, hold_cnt_d;

  assign timeout_hit = (hold_cnt_q == HoldLimit);

  always_comb begin
    hold_cnt_d = 8'd0;
    if (grant_entry) begin
      hold_cnt_d = 8'd0;
    end else if ((state_d == state_q) && (state_q != StIdle)) begin
      hold_cnt_d = (hold_cnt_q == 8'hff) ? hold_cnt_q : hold_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_q <= 8'd0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Next-state: level-sensitive requests, round-robin tie-break in idle,
  // direct hand-over between grant states with no idle bubble.
  always_comb begin
    state_d   = state_q;
    preempt_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_a && req_b) begin
          state_d = last_grant_q ? StGntA : StGntB;
        end else if (req_a) begin
          state_d = StGntA;
        end else if (req_b) begin
          state_d = StGntB;
        end
      end
      StGntA: begin
        if (timeout_hit && req_b) begin
          state_d   = StGntB;
          preempt_d = 1'b1;
        end else if (!req_a) begin
          state_d = req_b ? StGntB : StIdle;
        end
      end
      StGntB: begin
        if (timeout_hit && req_a) begin
          state_d   = StGntA;
          preempt_d = 1'b1;
        end else if (!req_b) begin
          state_d = req_a ? StGntA : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_entry) begin
      last_grant_d = (state_d == StGntB);
    end
  end

  // Grants and preempt are registered from the next state so they line up
  // exactly with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_a_q    <= 1'b0;
      grant_b_q    <= 1'b0;
      preempt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_a_q    <= (state_d == StGntA);
      grant_b_q    <= (state_d == StGntB);
      preempt_q    <= preempt_d;
    end
  end

  assign grant_a    = grant_a_q;
  assign grant_b    = grant_b_q;
  assign preempt    = preempt_q;
  assign Select_bit = (state_q == StGntB);

  always_comb begin
    Out = 1'b0;
    unique case (state_q)
      StGntA:  Out = A;
      StGntB:  Out = B;
      default: Out = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized bench for mux_rr_arbiter with an owner/last-winner reference model
// and a few hand-computed directed scenarios.

module tb_mux_rr_arbiter;

  localparam int unsigned TimeoutCycles = 4;

  logic clk;
  logic rst_n;
  logic req_a, req_b, A, B;
  logic grant_a, grant_b, Select_bit, Out, preempt;

  int n_cmp;
  int n_err;

  // Reference model: who owns the output, who won last, how long held.
  int owner;  // 0 none, 1 A, 2 B
  int last;   // 1 A, 2 B
  int held;   // cycles owned beyond the first
  bit pre;

  mux_rr_arbiter #(
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .req_b     (req_b),
    .A         (A),
    .B         (B),
    .grant_a   (grant_a),
    .grant_b   (grant_b),
    .Select_bit(Select_bit),
    .Out       (Out),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_update(input bit rst, input bit ra, input bit rb);
    bit mine, other;
    int nxt;
    pre = 1'b0;
    if (!rst) begin
      owner = 0;
      last  = 2;
      held  = 0;
      return;
    end
    if (owner == 0) begin
      nxt = 0;
      if (ra && rb) nxt = (last == 2) ? 1 : 2;
      else if (ra) nxt = 1;
      else if (rb) nxt = 2;
      if (nxt != 0) begin
        owner = nxt;
        last  = nxt;
        held  = 0;
      end
    end else begin
      mine  = (owner == 1) ? ra : rb;
      other = (owner == 1) ? rb : ra;
      nxt   = 3 - owner;
`ifdef MUX_ARB_TIMEOUT_EN
      if (held == int'(TimeoutCycles) - 1 && other) begin
        owner = nxt;
        last  = nxt;
        held  = 0;
        pre   = 1'b1;
      end else
`endif
      if (mine) begin
        if (held < 255) held++;
      end else if (other) begin
        owner = nxt;
        last  = nxt;
        held  = 0;
      end else begin
        owner = 0;
        held  = 0;
      end
    end
  endfunction

  // One clock: drive inputs, let the edge happen, update model, compare on
  // the falling edge.
  task automatic step(input bit rst, input bit ra, input bit rb, input bit a, input bit b);
    logic exp_out;
    rst_n = rst;
    req_a = ra;
    req_b = rb;
    A     = a;
    B     = b;
    @(posedge clk);
    model_update(rst, ra, rb);
    @(negedge clk);
    exp_out = (owner == 1) ? a : ((owner == 2) ? b : 1'b0);
    chk("grant_a", grant_a, owner == 1);
    chk("grant_b", grant_b, owner == 2);
    chk("Select_bit", Select_bit, owner == 2);
    chk("Out", Out, exp_out);
    chk("preempt", preempt, pre);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit ra, rb, rst;
    n_cmp = 0;
    n_err = 0;
    owner = 0;
    last  = 2;
    held  = 0;
    pre   = 1'b0;
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    A     = 1'b0;
    B     = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_grant_a", grant_a, 1'b0);
    chk("rst_grant_b", grant_b, 1'b0);
    chk("rst_sel", Select_bit, 1'b0);
    chk("rst_out", Out, 1'b0);
    chk("rst_preempt", preempt, 1'b0);

    // Single requester A, Out follows A
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("a_only_grant", grant_a, 1'b1);
    chk("a_only_out1", Out, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("a_only_out0", Out, 1'b0);
    chk("a_only_sel", Select_bit, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("a_only_out1b", Out, 1'b1);

    // Simultaneous requests: A first, then direct hand-over to B
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("both_first_a", grant_a, 1'b1);
    chk("both_first_nb", grant_b, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("handover_b", grant_b, 1'b1);
    chk("handover_out", Out, 1'b1);
    chk("handover_sel", Select_bit, 1'b1);

    // Reset mid-grant in GNT_B, then A wins after release
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("midrst_gb", grant_b, 1'b0);
    chk("midrst_out", Out, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("post_rst_a", grant_a, 1'b1);

    // Alternating contention
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("alt0_a", grant_a, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("alt1_b", grant_b, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("alt2_a", grant_a, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("alt3_b", grant_b, 1'b1);

    // Timeout hand-over (or indefinite hold when the feature is off)
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("to_hold_a", grant_a, 1'b1);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef MUX_ARB_TIMEOUT_EN
    chk("to_switch_b", grant_b, 1'b1);
    chk("to_preempt", preempt, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("to_preempt_pulse", preempt, 1'b0);
    chk("to_stay_b", grant_b, 1'b1);
`else
    chk("to_still_a", grant_a, 1'b1);
    chk("to_no_preempt", preempt, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("to_still_a_long", grant_a, 1'b1);
`endif

    // Randomized traffic with sticky requests and occasional resets
    do_reset();
    ra = 1'b0;
    rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) ra = ~ra;
      if ($urandom_range(3) == 0) rb = ~rb;
      rst = ($urandom_range(63) != 0);
      step(rst, ra, rb, 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
